pulse_shaper: RTL

- Downstream stage of the Poisson pulse generator. Consumes its one-cycle random trigger and emits a clean output pulse with programmable width.
- After each pulse it enforces a programmable dead time. Triggers landing in the busy window are dropped and counted.
- Optional burst mode stops after N accepted pulses. Accepted and dropped event counters are readable for rate verification.

---
 rtl/pulse_shaper.sv | 116 +++++++++++
 1 files changed

// File: rtl/pulse_shaper.sv
// Pulse shaper: turns one-cycle random triggers into fixed-width pulses followed
// by a dead time, with optional burst limiting and accepted/dropped event counters.
module pulse_shaper #(
  parameter int          CNT_BITS  = 32,
  parameter logic [15:0] DEF_WIDTH = 16'd10,
  parameter logic [15:0] DEF_DEAD  = 16'd100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig_in,
  input  logic [15:0]         width,
  input  logic                width_wr,
  input  logic [15:0]         dead,
  input  logic                dead_wr,
  input  logic [15:0]         burst_len,
  input  logic                enable,
  input  logic                clr_cnt,
  output logic                pulse_out,
  output logic                busy,
  output logic                burst_done,
  output logic [CNT_BITS-1:0] n_accepted,
  output logic [CNT_BITS-1:0] n_dropped
);

  typedef enum logic [1:0] {IDLE, HIGH, DEAD, DONE} state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] i_width, i_dead;
  logic [15:0] lat_dead, lat_burst, burst_cnt;
  logic        accept, drop, burst_hit, burst_clr;

  // Next-state logic; the burst counter already includes the current pulse
  // when the end-of-cycle decision is made.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = (state == IDLE) && enable && trig_in;
    drop      = (state != IDLE) && enable && trig_in;
    burst_hit = (lat_burst != 16'd0) && (burst_cnt == lat_burst);
    burst_clr = ((state == IDLE) || (state == DONE)) && !enable;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HIGH;
          cnt_nxt   = (i_width == 16'd0) ? 16'd0 : i_width - 16'd1;
        end
      end
      HIGH: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else if (lat_dead == 16'd0) begin
          state_nxt = burst_hit ? DONE : IDLE;
        end else begin
          state_nxt = DEAD;
          cnt_nxt   = lat_dead - 16'd1;
        end
      end
      DEAD: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          state_nxt = burst_hit ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      pulse_out  <= 1'b0;
      i_width    <= DEF_WIDTH;
      i_dead     <= DEF_DEAD;
      lat_dead   <= DEF_DEAD;
      lat_burst  <= 16'd0;
      burst_cnt  <= 16'd0;
      n_accepted <= '0;
      n_dropped  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse_out <= (state_nxt == HIGH);
      if (width_wr) i_width <= width;
      if (dead_wr)  i_dead  <= dead;
      // Dead time and burst length are frozen for the pulse being started.
      if (accept) begin
        lat_dead  <= i_dead;
        lat_burst <= burst_len;
        burst_cnt <= burst_cnt + 16'd1;
      end else if (burst_clr) begin
        burst_cnt <= 16'd0;
      end
      if (clr_cnt) begin
        n_accepted <= '0;
        n_dropped  <= '0;
      end else begin
        if (accept && (n_accepted != '1)) n_accepted <= n_accepted + CNT_ONE;
        if (drop && (n_dropped != '1))    n_dropped  <= n_dropped + CNT_ONE;
      end
    end
  end

  assign busy       = (state == HIGH) || (state == DEAD);
  assign burst_done = (state == DONE);

endmodule
